// File: rtl/axi_wr_burst_gen.sv
// AXI3 write-burst generator: queued commands drive AW/W with a seed+beat data pattern and are retired by in-order B responses.
// Optional response checking is enabled by defining AXI_WR_BURST_GEN_CHECK_EN.
module axi_wr_burst_gen #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 4,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [31:0]             cmd_seed,
  output logic [ID_WIDTH-1:0]     awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [LEN_WIDTH-1:0]    awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ID_WIDTH-1:0]     wid,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic                    busy,
  output logic [31:0]             done_cnt,
  output logic [15:0]             err_cnt
);

  localparam int IW    = $clog2(DEPTH);
  localparam int PW    = IW + 1;
  localparam int LANES = DATA_WIDTH / 32;

  typedef enum logic {AW_IDLE, AW_SEND} aw_state_t;
  typedef enum logic {W_IDLE, W_BEAT} w_state_t;

  logic [ADDR_WIDTH-1:0] r_buf_addr [DEPTH];
  logic [LEN_WIDTH-1:0]  r_buf_len  [DEPTH];
  logic [31:0]           r_buf_seed [DEPTH];
  logic [ID_WIDTH-1:0]   r_buf_id   [DEPTH];

  logic [PW-1:0]         r_wr_ptr, r_aw_ptr, r_w_ptr, r_b_ptr;
  logic [ID_WIDTH-1:0]   r_id_cnt;
  logic [31:0]           r_done_cnt;

  aw_state_t             r_aw_state, w_aw_state_nx;
  logic [ID_WIDTH-1:0]   r_awid;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [LEN_WIDTH-1:0]  r_awlen;

  w_state_t              r_w_state, w_w_state_nx;
  logic [ID_WIDTH-1:0]   r_wid;
  logic [31:0]           r_wword;
  logic [LEN_WIDTH-1:0]  r_wbeat, r_wlen;
  logic                  r_wlast;

  logic                  w_full, w_accept, w_aw_hs, w_aw_avail, w_aw_bypass, w_aw_load;
  logic                  w_w_hs, w_w_fin, w_w_avail, w_w_bypass, w_w_load;
  logic                  w_b_hs, w_b_inflight, w_retire;
  logic [PW-1:0]         w_wr_ptr_nx, w_aw_ptr_nx, w_w_ptr_nx, w_occ;
  logic [IW-1:0]         w_aw_idx, w_w_idx;

  assign w_occ       = r_wr_ptr - r_b_ptr;
  assign w_full      = (r_wr_ptr[PW-1] != r_b_ptr[PW-1]) && (r_wr_ptr[IW-1:0] == r_b_ptr[IW-1:0]);
  assign cmd_ready   = !rst && !w_full;
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_wr_ptr_nx = r_wr_ptr + PW'(w_accept);
  assign busy        = (w_occ != '0);
  assign bready      = !rst;

  // An entry accepted this edge is forwarded straight into an idle channel register.
  assign w_aw_hs     = (r_aw_state == AW_SEND) && awready;
  assign w_aw_ptr_nx = r_aw_ptr + PW'(w_aw_hs);
  assign w_aw_idx    = w_aw_ptr_nx[IW-1:0];
  assign w_aw_avail  = (w_aw_ptr_nx != w_wr_ptr_nx);
  assign w_aw_bypass = w_accept && (w_aw_ptr_nx == r_wr_ptr);
  assign w_aw_load   = ((r_aw_state == AW_IDLE) || w_aw_hs) && w_aw_avail;

  assign w_w_hs      = (r_w_state == W_BEAT) && wready;
  assign w_w_fin     = w_w_hs && r_wlast;
  assign w_w_ptr_nx  = r_w_ptr + PW'(w_w_fin);
  assign w_w_idx     = w_w_ptr_nx[IW-1:0];
  assign w_w_avail   = (w_w_ptr_nx != w_wr_ptr_nx);
  assign w_w_bypass  = w_accept && (w_w_ptr_nx == r_wr_ptr);
  assign w_w_load    = ((r_w_state == W_IDLE) || w_w_fin) && w_w_avail;

  assign w_b_hs       = bvalid && bready;
  assign w_b_inflight = (r_aw_ptr != r_b_ptr);
  assign w_retire     = w_b_hs && w_b_inflight;

  always_comb begin
    w_aw_state_nx = r_aw_state;
    if ((r_aw_state == AW_IDLE) || w_aw_hs)
      w_aw_state_nx = w_aw_avail ? AW_SEND : AW_IDLE;
  end

  always_comb begin
    w_w_state_nx = r_w_state;
    if ((r_w_state == W_IDLE) || w_w_fin)
      w_w_state_nx = w_w_avail ? W_BEAT : W_IDLE;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf_addr[r_wr_ptr[IW-1:0]] <= cmd_addr;
      r_buf_len[r_wr_ptr[IW-1:0]]  <= cmd_len;
      r_buf_seed[r_wr_ptr[IW-1:0]] <= cmd_seed;
      r_buf_id[r_wr_ptr[IW-1:0]]   <= r_id_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_aw_ptr   <= '0;
      r_w_ptr    <= '0;
      r_b_ptr    <= '0;
      r_id_cnt   <= '0;
      r_done_cnt <= '0;
      r_aw_state <= AW_IDLE;
      r_awid     <= '0;
      r_awaddr   <= '0;
      r_awlen    <= '0;
      r_w_state  <= W_IDLE;
      r_wid      <= '0;
      r_wword    <= '0;
      r_wbeat    <= '0;
      r_wlen     <= '0;
      r_wlast    <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nx;
      r_aw_ptr   <= w_aw_ptr_nx;
      r_w_ptr    <= w_w_ptr_nx;
      r_aw_state <= w_aw_state_nx;
      r_w_state  <= w_w_state_nx;
      if (w_accept) r_id_cnt <= r_id_cnt + 1'b1;
      if (w_retire) begin
        r_b_ptr    <= r_b_ptr + 1'b1;
        r_done_cnt <= r_done_cnt + 32'd1;
      end
      if (w_aw_load) begin
        r_awid   <= w_aw_bypass ? r_id_cnt : r_buf_id[w_aw_idx];
        r_awaddr <= w_aw_bypass ? cmd_addr : r_buf_addr[w_aw_idx];
        r_awlen  <= w_aw_bypass ? cmd_len  : r_buf_len[w_aw_idx];
      end
      if (w_w_load) begin
        r_wid   <= w_w_bypass ? r_id_cnt : r_buf_id[w_w_idx];
        r_wword <= w_w_bypass ? cmd_seed : r_buf_seed[w_w_idx];
        r_wlen  <= w_w_bypass ? cmd_len  : r_buf_len[w_w_idx];
        r_wbeat <= '0;
        r_wlast <= ((w_w_bypass ? cmd_len : r_buf_len[w_w_idx]) == '0);
      end else if (w_w_hs) begin
        if (r_wlast) begin
          r_wlast <= 1'b0;
        end else begin
          r_wword <= r_wword + 32'd1;
          r_wbeat <= LEN_WIDTH'(r_wbeat + 1'b1);
          r_wlast <= (LEN_WIDTH'(r_wbeat + 1'b1) == r_wlen);
        end
      end
    end
  end

  assign awid     = r_awid;
  assign awaddr   = r_awaddr;
  assign awlen    = r_awlen;
  assign awsize   = 3'($clog2(DATA_WIDTH/8));
  assign awburst  = 2'b01;
  assign awvalid  = (r_aw_state == AW_SEND);
  assign wid      = r_wid;
  assign wdata    = {LANES{r_wword}};
  assign wstrb    = '1;
  assign wlast    = r_wlast;
  assign wvalid   = (r_w_state == W_BEAT);
  assign done_cnt = r_done_cnt;

`ifdef AXI_WR_BURST_GEN_CHECK_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] r_err_cnt;
  logic        w_b_err;

  assign w_b_err = w_b_hs && (!w_b_inflight || (bresp != 2'b00) || (bid != r_buf_id[r_b_ptr[IW-1:0]]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_err_cnt <= '0;
    else if (w_b_err) r_err_cnt <= sat_inc(r_err_cnt);
  end

  assign err_cnt = r_err_cnt;
`else
  logic w_unused_b;
  assign w_unused_b = ^{bid, bresp};
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_axi_wr_burst_gen.sv
// Scoreboard bench for axi_wr_burst_gen: stimulus pushes expected AW/W traffic, a negedge monitor pops and compares.
module tb_axi_wr_burst_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [31:0]  cmd_addr;
  logic [3:0]   cmd_len;
  logic [31:0]  cmd_seed;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [3:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid, awready;
  logic [3:0]   wid;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast, wvalid, wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid, bready, busy;
  logic [31:0]  done_cnt;
  logic [15:0]  err_cnt;

  axi_wr_burst_gen #(
    .DATA_WIDTH(128), .ADDR_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(4), .DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .busy(busy), .done_cnt(done_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] id; logic [31:0] addr; logic [3:0] len; } aw_t;
  typedef struct { logic [3:0] id; logic [127:0] data; logic last; } w_t;

  aw_t        exp_aw[$];
  w_t         exp_w[$];
  logic [3:0] pend_q[$];
  aw_t        ea;
  w_t         ew;

  int checks = 0;
  int errors = 0;
  int aw_cnt = 0, wl_cnt = 0, wb_cnt = 0, b_sent = 0, wl_target = 0;
  logic [3:0] tb_id = 4'd0;
  logic aw_hold = 1'b0, w_toggle = 1'b0;
  logic aw_stall = 1'b0, w_stall = 1'b0;
  logic [31:0]  sv_awaddr;
  logic [3:0]   sv_awid;
  logic [127:0] sv_wdata;
  logic         sv_wlast;
`ifdef AXI_WR_BURST_GEN_CHECK_EN
  localparam logic [15:0] EXP_ERR = 16'd3;
`else
  localparam logic [15:0] EXP_ERR = 16'd0;
`endif

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout required completion", nm);
  endtask

  // Slave ready behaviour, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    awready = !aw_hold;
    wready  = w_toggle ? ~wready : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      aw_stall = 1'b0;
      w_stall  = 1'b0;
    end else begin
      if (aw_stall && awvalid) begin
        check("aw_stable_addr", awaddr, sv_awaddr);
        check("aw_stable_id", awid, sv_awid);
      end
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) begin
          fail("aw_unexpected");
        end else begin
          ea = exp_aw.pop_front();
          check("awid", awid, ea.id);
          check("awaddr", awaddr, ea.addr);
          check("awlen", awlen, ea.len);
          check("awsize", awsize, 3'd4);
          check("awburst", awburst, 2'b01);
        end
        aw_cnt++;
      end
      aw_stall  = awvalid && !awready;
      sv_awaddr = awaddr;
      sv_awid   = awid;

      if (w_stall && wvalid) begin
        check("w_stable_data", wdata, sv_wdata);
        check("w_stable_last", wlast, sv_wlast);
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) begin
          fail("w_unexpected");
        end else begin
          ew = exp_w.pop_front();
          check("wid", wid, ew.id);
          check("wdata", wdata, ew.data);
          check("wlast", wlast, ew.last);
          check("wstrb", wstrb, 16'hFFFF);
        end
        wb_cnt++;
        if (wlast) begin
          wl_cnt++;
          pend_q.push_back(wid);
        end
      end
      w_stall  = wvalid && !wready;
      sv_wdata = wdata;
      sv_wlast = wlast;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [31:0] addr, input logic [3:0] len, input logic [31:0] seed);
    aw_t a;
    w_t  w;
    logic [31:0] v;
    int t = 0;
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len; cmd_seed = seed;
    @(negedge clk);
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      fail("cmd_accept");
      cmd_valid = 1'b0;
      return;
    end
    a.id = tb_id; a.addr = addr; a.len = len;
    exp_aw.push_back(a);
    for (int k = 0; k <= int'(len); k++) begin
      v = seed + 32'(k);
      w.id = tb_id; w.data = {4{v}}; w.last = (k == int'(len));
      exp_w.push_back(w);
    end
    tb_id++;
    wl_target++;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_wl();
    int t = 0;
    while (wl_cnt < wl_target && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (wl_cnt < wl_target) fail("wait_wlast");
  endtask

  task automatic send_b(input logic [3:0] id, input logic [1:0] resp);
    bvalid = 1'b1; bid = id; bresp = resp;
    @(posedge clk); #1;
    bvalid = 1'b0; bid = '0; bresp = '0;
  endtask

  task automatic drain_b(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while ((pend_q.size() == 0 || aw_cnt <= b_sent) && t < 300) begin
        @(posedge clk); #1;
        t++;
      end
      if (pend_q.size() == 0 || aw_cnt <= b_sent) begin
        fail("wait_b_ready");
        return;
      end
      send_b(pend_q.pop_front(), 2'b00);
      b_sent++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_seed = '0;
    bvalid = 1'b0; bid = '0; bresp = '0; awready = 1'b1; wready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_bready", bready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_wlast", wlast, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_cnt, 0);
    check("rst_err", err_cnt, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_wdata", wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("run_bready", bready, 1);
    check("run_cmd_ready", cmd_ready, 1);

    // Single 2-beat burst
    issue(32'h0, 4'd1, 32'h01234567);
    check("aw_lat", awvalid, 1);
    check("w_lat", wvalid, 1);
    check("busy_single", busy, 1);
    wait_wl();
    drain_b(1);
    @(posedge clk); #1;
    check("done_single", done_cnt, 1);
    check("err_single", err_cnt, 0);
    check("idle_single", busy, 0);

    // Back-pressure on AW and W, 16-beat burst
    aw_hold = 1'b1; w_toggle = 1'b1;
    @(posedge clk); #1;
    issue(32'h0000_1000, 4'd15, 32'hA5A5_0000);
    repeat (5) @(posedge clk);
    #1;
    check("aw_held", awvalid, 1);
    check("aw_held_addr", awaddr, 32'h0000_1000);
    aw_hold = 1'b0;
    wait_wl();
    w_toggle = 1'b0;
    drain_b(1);
    @(posedge clk); #1;
    check("done_bp", done_cnt, 2);

    // Fill the buffer with B withheld
    for (int i = 0; i < 4; i++) issue(32'h100 * (i + 1), 4'd0, 32'h1000 + 32'(i));
    wait_wl();
    cmd_valid = 1'b1; cmd_addr = 32'h500; cmd_len = 4'd0; cmd_seed = 32'h2000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_ready", cmd_ready, 0);
    end
    @(posedge clk); #1;
    send_b(pend_q.pop_front(), 2'b00);
    b_sent++;
    check("ready_after_b", cmd_ready, 1);
    issue(32'h500, 4'd0, 32'h2000);
    drain_b(1);
    issue(32'h600, 4'd0, 32'h2001);
    wait_wl();
    drain_b(4);
    @(posedge clk); #1;
    check("done_full", done_cnt, 8);

    // Seed wraps across 32 bits
    issue(32'h0000_2000, 4'd2, 32'hFFFF_FFFF);
    wait_wl();
    drain_b(1);
    @(posedge clk); #1;
    check("done_wrap", done_cnt, 9);

    // Error responses: SLVERR, wrong id, spurious B
    issue(32'h3000, 4'd0, 32'h3000);
    wait_wl();
    t = 0;
    while (aw_cnt <= b_sent && t < 100) begin @(posedge clk); #1; t++; end
    send_b(pend_q.pop_front(), 2'b10);
    b_sent++;
    issue(32'h3100, 4'd0, 32'h3100);
    wait_wl();
    t = 0;
    while (aw_cnt <= b_sent && t < 100) begin @(posedge clk); #1; t++; end
    send_b(pend_q.pop_front() ^ 4'h1, 2'b00);
    b_sent++;
    @(posedge clk); #1;
    check("idle_err", busy, 0);
    send_b(4'h7, 2'b00);
    @(posedge clk); #1;
    check("err_cnt", err_cnt, EXP_ERR);
    check("done_err", done_cnt, 11);

    // Reset in the middle of an 8-beat burst
    issue(32'h4000, 4'd7, 32'h4000);
    t = wb_cnt;
    while (wb_cnt < t + 3 && t < 100000) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_awvalid", awvalid, 0);
    check("mid_rst_wvalid", wvalid, 0);
    check("mid_rst_wlast", wlast, 0);
    check("mid_rst_done", done_cnt, 0);
    check("mid_rst_err", err_cnt, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    exp_aw.delete();
    exp_w.delete();
    pend_q.delete();
    tb_id = 4'd0;
    wl_target = wl_cnt;
    b_sent = aw_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(32'h5000, 4'd1, 32'h5000);
    wait_wl();
    drain_b(1);
    @(posedge clk); #1;
    check("done_after_rst", done_cnt, 1);
    check("idle_end", busy, 0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_aw_empty", exp_aw.size(), 0);
    check("sb_w_empty", exp_w.size(), 0);
    check("sb_b_empty", pend_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
